// File: rtl/pc_unit_if.sv
// Signal bundle between the fetch/decode logic and the program-counter unit.
// There is no valid/ready handshake: the controls are sampled on every rising edge; stall is the only hold.
interface pc_unit_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9
);
  logic              stall;
  logic              is_branch;
  logic              is_branch_reg;
  logic              is_halt;
  logic [2:0]        cond;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] reg_target;
  logic [2:0]        flag;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] pc_plus;
  logic              taken;
  logic              halted;
  logic              state_dbg;

  modport master (
    output stall, is_branch, is_branch_reg, is_halt, cond, imm, reg_target, flag,
    input  pc_addr, pc_plus, taken, halted, state_dbg
  );

  modport slave (
    input  stall, is_branch, is_branch_reg, is_halt, cond, imm, reg_target, flag,
    output pc_addr, pc_plus, taken, halted, state_dbg
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and selects the next PC from
// sequential, relative-branch, register-branch, stall-hold and halt sources.
module pc_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                IMM_W       = 9,
  parameter int                INSTR_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  localparam int                SHIFT = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(INSTR_BYTES);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_rel_target;
  logic [ADDR_W-1:0] w_target;
  logic              w_flag_z;
  logic              w_flag_v;
  logic              w_flag_n;
  logic              w_cond_true;
  logic              w_branch_taken;
  logic              w_advance;
  logic              w_taken;

  assign w_flag_z = bus.flag[2];
  assign w_flag_v = bus.flag[1];
  assign w_flag_n = bus.flag[0];

  // Offset is in instruction units, so it is scaled to bytes before the add.
  assign w_pc_plus    = r_pc + INC;
  assign w_imm_ext    = {{(ADDR_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign w_rel_target = w_pc_plus + (w_imm_ext << SHIFT);
  assign w_target     = bus.is_branch_reg ? bus.reg_target : w_rel_target;

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      3'b000:  w_cond_true = ~w_flag_z;
      3'b001:  w_cond_true = w_flag_z;
      3'b010:  w_cond_true = ~w_flag_z & ~w_flag_n;
      3'b011:  w_cond_true = w_flag_n;
      3'b100:  w_cond_true = w_flag_z | (~w_flag_z & ~w_flag_n);
      3'b101:  w_cond_true = w_flag_n | w_flag_z;
      3'b110:  w_cond_true = w_flag_v;
      3'b111:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_branch_taken = (bus.is_branch | bus.is_branch_reg) & w_cond_true;

  // Only an unstalled, non-halting RUN cycle moves the PC.
  assign w_advance = (r_state == S_RUN) & ~bus.stall & ~bus.is_halt;
  assign w_taken   = rst & w_advance & w_branch_taken;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_VEC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_RUN: begin
        if (!bus.stall) begin
          if (bus.is_halt) begin
            w_next_state = S_HALT;
          end else if (w_branch_taken) begin
            w_pc_next = w_target;
          end else begin
            w_pc_next = w_pc_plus;
          end
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    bus.pc_addr   = r_pc;
    bus.pc_plus   = w_pc_plus;
    bus.taken     = w_taken;
    bus.halted    = (r_state == S_HALT);
    bus.state_dbg = r_state;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: an abstract PC model checked every negedge, plus
// directed vectors with hand-computed expectations.
module tb_pc_unit;

  localparam int ADDR_W = 16;
  localparam int IMM_W  = 9;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic chk_en;

  // Abstract model state.
  int   m_pc;
  logic m_halt;

  logic [7:0] masks [8];

  pc_unit_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) bus ();

  pc_unit #(
    .ADDR_W(ADDR_W), .IMM_W(IMM_W), .INSTR_BYTES(2), .RESET_VEC(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic m_take_now();
    return rst && !m_halt && !bus.stall && !bus.is_halt &&
           (bus.is_branch || bus.is_branch_reg) && cond_ok(bus.cond, bus.flag);
  endfunction

  function automatic int m_target();
    if (bus.is_branch_reg) return int'(bus.reg_target);
    return (m_pc + 2 + 2 * int'($signed(bus.imm))) & 32'hFFFF;
  endfunction

  // Model: PC as plain modular integer arithmetic.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc   <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt && !bus.stall) begin
      if (bus.is_halt)      m_halt <= 1'b1;
      else if (m_take_now()) m_pc  <= m_target();
      else                   m_pc  <= (m_pc + 2) & 32'hFFFF;
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc_addr", 32'(bus.pc_addr), m_pc);
      check("cyc_pc_plus", 32'(bus.pc_plus), (m_pc + 2) & 32'hFFFF);
      check("cyc_taken",   32'(bus.taken),   32'(m_take_now()));
      check("cyc_halted",  32'(bus.halted),  32'(m_halt));
    end
  end

  // Driver tasks.
  task automatic clear_inputs();
    bus.stall = 0; bus.is_branch = 0; bus.is_branch_reg = 0; bus.is_halt = 0;
    bus.cond = 3'd0; bus.imm = '0; bus.reg_target = '0; bus.flag = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [15:0] a);
    bus.is_branch_reg = 1; bus.cond = 3'd7; bus.reg_target = a;
    step();
    clear_inputs();
    check("goto_pc", 32'(bus.pc_addr), 32'(a));
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 0;
    m_pc = 0; m_halt = 0;
    masks[0] = 8'h0F; masks[1] = 8'hF0; masks[2] = 8'h05; masks[3] = 8'hAA;
    masks[4] = 8'hF5; masks[5] = 8'hFA; masks[6] = 8'hCC; masks[7] = 8'hFF;
    clear_inputs();
    rst = 1'b0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 32'(bus.pc_addr), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    bus.is_branch = 1; bus.cond = 3'd7;
    #1;
    check("rst_taken", 32'(bus.taken), 32'h0);
    clear_inputs();

    // Reset vector and sequential increment.
    rst = 1'b1;
    check("rv_pc0", 32'(bus.pc_addr), 32'h0000);
    step(); check("rv_pc1", 32'(bus.pc_addr), 32'h0002);
    step(); check("rv_pc2", 32'(bus.pc_addr), 32'h0004);
    check("rv_halted", 32'(bus.halted), 32'h0);

    // Relative branch, condition true then false.
    go_to(16'h0010);
    bus.is_branch = 1; bus.cond = 3'b001; bus.flag = 3'b100; bus.imm = 9'h1FE;
    #1 check("rel_taken", 32'(bus.taken), 32'h1);
    step(); check("rel_pc", 32'(bus.pc_addr), 32'h000E);
    clear_inputs();
    go_to(16'h0010);
    bus.is_branch = 1; bus.cond = 3'b001; bus.flag = 3'b000; bus.imm = 9'h1FE;
    #1 check("rel_nt_taken", 32'(bus.taken), 32'h0);
    step(); check("rel_nt_pc", 32'(bus.pc_addr), 32'h0012);
    clear_inputs();

    // Register branch, priority over relative, unaligned target.
    go_to(16'h0040);
    bus.is_branch_reg = 1; bus.cond = 3'b111; bus.reg_target = 16'h1234;
    step(); check("reg_pc", 32'(bus.pc_addr), 32'h1234);
    bus.is_branch = 1; bus.imm = 9'h004; bus.reg_target = 16'h1235;
    step(); check("reg_prio_pc", 32'(bus.pc_addr), 32'h1235);
    clear_inputs();

    // Wrap-around in both directions, largest positive offset.
    go_to(16'hFFFE);
    check("wrap_plus", 32'(bus.pc_plus), 32'h0000);
    step(); check("wrap_fwd", 32'(bus.pc_addr), 32'h0000);
    bus.is_branch = 1; bus.cond = 3'd7; bus.imm = 9'h1FC;
    step(); check("wrap_back", 32'(bus.pc_addr), 32'hFFFA);
    clear_inputs();
    go_to(16'h0100);
    bus.is_branch = 1; bus.cond = 3'd7; bus.imm = 9'h0FF;
    step(); check("imm_max", 32'(bus.pc_addr), 32'h0300);
    clear_inputs();

    // Stall holds and masks the branch; branch applies once stall drops.
    go_to(16'h0020);
    bus.stall = 1; bus.is_branch = 1; bus.cond = 3'd7; bus.imm = 9'h010;
    #1 check("stall_taken", 32'(bus.taken), 32'h0);
    step(); check("stall_pc1", 32'(bus.pc_addr), 32'h0020);
    step(); check("stall_pc2", 32'(bus.pc_addr), 32'h0020);
    bus.stall = 0;
    #1 check("unstall_taken", 32'(bus.taken), 32'h1);
    step(); check("unstall_pc", 32'(bus.pc_addr), 32'h0042);
    clear_inputs();

    // Stall also masks is_halt.
    bus.stall = 1; bus.is_halt = 1;
    step(); check("stall_halt", 32'(bus.halted), 32'h0);
    clear_inputs();

    // Condition sweep against hand-built truth masks.
    bus.is_branch = 1; bus.imm = 9'h003;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [7:0] mk;
        mk = masks[c];
        bus.cond = 3'(c); bus.flag = 3'(f);
        #1 check($sformatf("cond%0d_f%0d", c, f), 32'(bus.taken), 32'(mk[f]));
        step();
      end
    end
    clear_inputs();

    // Halt wins over a branch, then freezes for 10 cycles.
    go_to(16'h0030);
    bus.is_halt = 1; bus.is_branch = 1; bus.cond = 3'd7; bus.imm = 9'h020;
    #1 check("halt_taken", 32'(bus.taken), 32'h0);
    step();
    check("halt_flag", 32'(bus.halted), 32'h1);
    check("halt_pc", 32'(bus.pc_addr), 32'h0030);
    for (int i = 0; i < 10; i++) begin
      bus.is_halt = 0;
      bus.stall = 1'($urandom_range(0, 1));
      bus.is_branch = 1'($urandom_range(0, 1));
      bus.is_branch_reg = 1'($urandom_range(0, 1));
      bus.cond = 3'd7;
      bus.reg_target = 16'($urandom_range(0, 16'hFFFF));
      bus.imm = 9'($urandom_range(0, 9'h1FF));
      #1 check("halt_hold_taken", 32'(bus.taken), 32'h0);
      step();
      check("halt_hold_pc", 32'(bus.pc_addr), 32'h0030);
      check("halt_hold_plus", 32'(bus.pc_plus), 32'h0032);
    end
    clear_inputs();

    // Asynchronous reset in the middle of a cycle while halted.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_pc", 32'(bus.pc_addr), 32'h0000);
    check("arst_halted", 32'(bus.halted), 32'h0);
    step();
    rst = 1'b1;
    check("rel_rst_pc", 32'(bus.pc_addr), 32'h0000);
    step(); check("resume_pc", 32'(bus.pc_addr), 32'h0002);
    step(); check("resume_pc2", 32'(bus.pc_addr), 32'h0004);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
